// File: rtl/tmds_pkg.sv
// Shared definitions for the per-lane TMDS encoder: symbol modes, fixed
// control/guard words and the TERC4 code table.
package tmds_pkg;

    typedef enum logic [1:0] {
        MODE_CTRL  = 2'd0,
        MODE_VIDEO = 2'd1,
        MODE_TERC4 = 2'd2,
        MODE_GUARD = 2'd3
    } mode_e;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    localparam logic [9:0] GB_VIDEO_0_2 = 10'b1011001100;
    localparam logic [9:0] GB_VIDEO_1   = 10'b0100110011;

    function automatic logic [9:0] ctrl_token(input logic [1:0] ctrl);
        logic [9:0] word;
        case (ctrl)
            2'b00:   word = CTRL_TOKEN_00;
            2'b01:   word = CTRL_TOKEN_01;
            2'b10:   word = CTRL_TOKEN_10;
            default: word = CTRL_TOKEN_11;
        endcase
        return word;
    endfunction

    function automatic logic [9:0] terc4_lut(input logic [3:0] nibble);
        logic [9:0] word;
        case (nibble)
            4'h0:    word = 10'b1010011100;
            4'h1:    word = 10'b1001100011;
            4'h2:    word = 10'b1011100100;
            4'h3:    word = 10'b1011100010;
            4'h4:    word = 10'b0101110001;
            4'h5:    word = 10'b0100011110;
            4'h6:    word = 10'b0110001110;
            4'h7:    word = 10'b0100111100;
            4'h8:    word = 10'b1011001100;
            4'h9:    word = 10'b0100111001;
            4'hA:    word = 10'b0110011100;
            4'hB:    word = 10'b1011000110;
            4'hC:    word = 10'b1010001110;
            4'hD:    word = 10'b1001110001;
            4'hE:    word = 10'b0101100011;
            default: word = 10'b1011000011;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Stage 1 of the TMDS encoder: transition-minimising XOR/XNOR chain plus the
// ones/zeros counts of the result, registered alongside the symbol request.
module tmds_qm_stage
    import tmds_pkg::*;
(
    input  logic       i_pclk,
    input  logic       i_rst,
    input  logic [1:0] i_mode,
    input  logic [7:0] i_data,
    input  logic [1:0] i_ctrl,
    input  logic [3:0] i_aux,
    output logic [1:0] o_mode,
    output logic [1:0] o_ctrl,
    output logic [3:0] o_aux,
    output logic [8:0] o_qm,
    output logic [3:0] o_n1q,
    output logic [3:0] o_n0q
);

    mode_e      mode_d, mode_q;
    logic [1:0] ctrl_d, ctrl_q;
    logic [3:0] aux_d, aux_q;
    logic [8:0] qm_d, qm_q;
    logic [3:0] n1q_d, n1q_q;
    logic [3:0] n0q_d, n0q_q;
    logic [3:0] n1d;
    logic       use_xnor;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write so
        // the block stays purely combinational and no latch is inferred.
        n1d      = '0;
        qm_d     = '0;
        n1q_d    = '0;
        mode_d   = mode_e'(i_mode);
        ctrl_d   = i_ctrl;
        aux_d    = i_aux;

        for (int i = 0; i < 8; i++) begin
            n1d = n1d + 4'(i_data[i]);
        end
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !i_data[0]);

        qm_d[0] = i_data[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ i_data[i]) : (qm_d[i-1] ^ i_data[i]);
        end
        qm_d[8] = ~use_xnor;

        for (int i = 0; i < 8; i++) begin
            n1q_d = n1q_d + 4'(qm_d[i]);
        end
        n0q_d = 4'd8 - n1q_d;
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            mode_q <= MODE_CTRL;
            ctrl_q <= 2'b00;
            aux_q  <= '0;
            qm_q   <= '0;
            n1q_q  <= '0;
            n0q_q  <= '0;
        end else begin
            mode_q <= mode_d;
            ctrl_q <= ctrl_d;
            aux_q  <= aux_d;
            qm_q   <= qm_d;
            n1q_q  <= n1q_d;
            n0q_q  <= n0q_d;
        end
    end

    assign o_mode = mode_q;
    assign o_ctrl = ctrl_q;
    assign o_aux  = aux_q;
    assign o_qm   = qm_q;
    assign o_n1q  = n1q_q;
    assign o_n0q  = n0q_q;

endmodule

// File: rtl/tmds_encoder.sv
// Per-lane TMDS encoder: stage 1 builds qm, stage 2 applies DC balancing or
// selects the control/TERC4/guard word and registers the 10-bit symbol.
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic       i_pclk,
    input  logic       i_rst,
    input  logic [1:0] i_mode,
    input  logic [7:0] i_data,
    input  logic [1:0] i_ctrl,
    input  logic [3:0] i_aux,
    output logic [9:0] o_data
);

    logic [1:0] s1_mode;
    logic [1:0] s1_ctrl;
    logic [3:0] s1_aux;
    logic [8:0] s1_qm;
    logic [3:0] s1_n1q;
    logic [3:0] s1_n0q;

    tmds_qm_stage u_qm_stage (
        .i_pclk (i_pclk),
        .i_rst  (i_rst),
        .i_mode (i_mode),
        .i_data (i_data),
        .i_ctrl (i_ctrl),
        .i_aux  (i_aux),
        .o_mode (s1_mode),
        .o_ctrl (s1_ctrl),
        .o_aux  (s1_aux),
        .o_qm   (s1_qm),
        .o_n1q  (s1_n1q),
        .o_n0q  (s1_n0q)
    );

    logic [9:0]        data_d, data_q;
    logic signed [5:0] cnt_d, cnt_q;
    logic signed [5:0] diff;
    logic              qm8;

    always_comb begin
        data_d = CTRL_TOKEN_00;
        cnt_d  = '0;
        qm8    = s1_qm[8];
        diff   = $signed({2'b00, s1_n1q}) - $signed({2'b00, s1_n0q});

        case (mode_e'(s1_mode))
            MODE_VIDEO: begin
                if ((cnt_q == 6'sd0) || (s1_n1q == s1_n0q)) begin
                    data_d = {~qm8, qm8, qm8 ? s1_qm[7:0] : ~s1_qm[7:0]};
                    cnt_d  = qm8 ? (cnt_q + diff) : (cnt_q - diff);
                end else if (((cnt_q > 6'sd0) && (s1_n1q > s1_n0q)) ||
                             ((cnt_q < 6'sd0) && (s1_n0q > s1_n1q))) begin
                    data_d = {1'b1, qm8, ~s1_qm[7:0]};
                    cnt_d  = cnt_q + (qm8 ? 6'sd2 : 6'sd0) - diff;
                end else begin
                    data_d = {1'b0, qm8, s1_qm[7:0]};
                    cnt_d  = cnt_q + diff - (qm8 ? 6'sd0 : 6'sd2);
                end
            end
            MODE_CTRL:  data_d = ctrl_token(s1_ctrl);
            MODE_TERC4: data_d = terc4_lut(s1_aux);
            MODE_GUARD: data_d = (CHANNEL == 1) ? GB_VIDEO_1 : GB_VIDEO_0_2;
            default:    data_d = CTRL_TOKEN_00;
        endcase
    end

    // Any non-VIDEO symbol leaves cnt_d at its zero default, restarting disparity.
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            data_q <= CTRL_TOKEN_00;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_data = data_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed symbols plus a random video
// stream compared against an arithmetic reference model of TMDS encoding.
module tb_tmds_encoder;

    logic       i_pclk = 1'b0;
    logic       i_rst  = 1'b0;
    logic [1:0] i_mode = 2'd0;
    logic [7:0] i_data = 8'd0;
    logic [1:0] i_ctrl = 2'd0;
    logic [3:0] i_aux  = 4'd0;
    logic [9:0] o_data0;
    logic [9:0] o_data1;

    always #5 i_pclk = ~i_pclk;

    tmds_encoder #(.CHANNEL(0)) dut0 (
        .i_pclk (i_pclk),
        .i_rst  (i_rst),
        .i_mode (i_mode),
        .i_data (i_data),
        .i_ctrl (i_ctrl),
        .i_aux  (i_aux),
        .o_data (o_data0)
    );

    tmds_encoder #(.CHANNEL(1)) dut1 (
        .i_pclk (i_pclk),
        .i_rst  (i_rst),
        .i_mode (i_mode),
        .i_data (i_data),
        .i_ctrl (i_ctrl),
        .i_aux  (i_aux),
        .o_data (o_data1)
    );

    logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011,
                                 10'b0101010100, 10'b1010101011};
    logic [9:0] terc4_tab [16] = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                                   10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                                   10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                                   10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    typedef struct {
        logic [9:0] word0;
        logic [9:0] word1;
        int         cnt;
        bit         is_video;
        logic [7:0] byte_v;
        bit         has_lit;
        logic [9:0] lit_word;
        int         lit_cnt;
        string      tag;
    } entry_t;

    entry_t s1;
    bit     s1_valid  = 1'b0;
    int     model_cnt = 0;
    int     n_checks  = 0;
    int     n_fail    = 0;

    task automatic chk_word(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected within %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Reference: TMDS rules evaluated with integer popcounts and balances.
    function automatic logic [9:0] model_encode(input logic [1:0] m, input logic [7:0] d,
                                                input logic [1:0] c, input logic [3:0] a,
                                                input int ch, input int cnt_in,
                                                output int cnt_out);
        logic [7:0] qm;
        bit         xnor_path;
        bit         q8;
        bit         inv;
        int         bal;
        cnt_out = 0;
        if (m == 2'd0) return ctrl_tab[c];
        if (m == 2'd2) return terc4_tab[a];
        if (m == 2'd3) return (ch == 1) ? 10'b0100110011 : 10'b1011001100;
        xnor_path = ($countones(d) > 4) || ($countones(d) == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xnor_path ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        q8  = !xnor_path;
        bal = 2 * $countones(qm) - 8;
        if (cnt_in == 0 || bal == 0) begin
            inv     = !q8;
            cnt_out = cnt_in + (q8 ? bal : -bal);
        end else if ((cnt_in > 0 && bal > 0) || (cnt_in < 0 && bal < 0)) begin
            inv     = 1'b1;
            cnt_out = cnt_in + 2 * int'(q8) - bal;
        end else begin
            inv     = 1'b0;
            cnt_out = cnt_in + bal - (q8 ? 0 : 2);
        end
        return {inv, q8, inv ? ~qm : qm};
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] w);
        logic [7:0] q;
        logic [7:0] b;
        q    = w[9] ? ~w[7:0] : w[7:0];
        b[0] = q[0];
        for (int i = 1; i < 8; i++) b[i] = w[8] ? (q[i] ^ q[i-1]) : !(q[i] ^ q[i-1]);
        return b;
    endfunction

    task automatic check_entry(input entry_t e);
        chk_word({e.tag, " ch0 word"}, o_data0, e.word0);
        chk_word({e.tag, " ch1 word"}, o_data1, e.word1);
        chk_int({e.tag, " cnt"}, int'(dut0.cnt_q), e.cnt);
        if (e.has_lit) begin
            chk_word({e.tag, " literal word"}, o_data0, e.lit_word);
            chk_int({e.tag, " literal cnt"}, int'(dut0.cnt_q), e.lit_cnt);
        end
        if (e.is_video) begin
            chk_word({e.tag, " decoded byte"}, {2'b00, decode(o_data0)}, {2'b00, e.byte_v});
            chk_range({e.tag, " cnt bound"}, int'(dut0.cnt_q), -10, 10);
        end
    endtask

    // One pixel-clock symbol; checks the symbol issued on the previous step.
    task automatic step(input logic [1:0] m, input logic [7:0] d, input logic [1:0] c,
                        input logic [3:0] a, input string tag, input bit has_lit = 1'b0,
                        input logic [9:0] lit_word = 10'd0, input int lit_cnt = 0);
        entry_t e;
        int     nc;
        i_rst  = 1'b0;
        i_mode = m;
        i_data = d;
        i_ctrl = c;
        i_aux  = a;
        @(posedge i_pclk);
        #1;
        if (s1_valid) check_entry(s1);
        e.word0    = model_encode(m, d, c, a, 0, model_cnt, nc);
        e.word1    = model_encode(m, d, c, a, 1, model_cnt, nc);
        model_cnt  = nc;
        e.cnt      = nc;
        e.is_video = (m == 2'd1);
        e.byte_v   = d;
        e.has_lit  = has_lit;
        e.lit_word = lit_word;
        e.lit_cnt  = lit_cnt;
        e.tag      = tag;
        s1         = e;
        s1_valid   = 1'b1;
    endtask

    task automatic reset_edge(input string tag);
        i_rst  = 1'b1;
        i_mode = 2'd1;
        i_data = 8'($urandom);
        i_ctrl = 2'($urandom);
        i_aux  = 4'($urandom);
        @(posedge i_pclk);
        #1;
        chk_word({tag, " ch0 word"}, o_data0, 10'b1101010100);
        chk_word({tag, " ch1 word"}, o_data1, 10'b1101010100);
        chk_int({tag, " cnt"}, int'(dut0.cnt_q), 0);
        s1.word0    = 10'b1101010100;
        s1.word1    = 10'b1101010100;
        s1.cnt      = 0;
        s1.is_video = 1'b0;
        s1.byte_v   = 8'd0;
        s1.has_lit  = 1'b0;
        s1.lit_word = 10'd0;
        s1.lit_cnt  = 0;
        s1.tag      = {tag, " flushed stage1"};
        s1_valid    = 1'b1;
        model_cnt   = 0;
    endtask

    initial begin
        reset_edge("reset1");
        reset_edge("reset2");
        step(2'd0, 8'($urandom), 2'b00, 4'($urandom), "idle");
        step(2'd0, 8'($urandom), 2'b11, 4'($urandom), "ctrl11", 1'b1, 10'b1010101011, 0);
        step(2'd0, 8'($urandom), 2'b00, 4'($urandom), "ctrl00", 1'b1, 10'b1101010100, 0);
        step(2'd1, 8'h00, 2'($urandom), 4'($urandom), "vid00_first", 1'b1, 10'b0100000000, -8);
        step(2'd1, 8'h00, 2'($urandom), 4'($urandom), "vid00_second", 1'b1, 10'b1111111111, 2);
        step(2'd0, 8'($urandom), 2'b01, 4'($urandom), "ctrl01", 1'b1, 10'b0010101011, 0);
        step(2'd1, 8'hFF, 2'($urandom), 4'($urandom), "vidFF", 1'b1, 10'b1000000000, -8);
        step(2'd0, 8'($urandom), 2'b10, 4'($urandom), "ctrl10", 1'b1, 10'b0101010100, 0);
        step(2'd1, 8'h00, 2'($urandom), 4'($urandom), "mix_vid1", 1'b1, 10'b0100000000, -8);
        step(2'd0, 8'($urandom), 2'b00, 4'($urandom), "mix_ctrl", 1'b1, 10'b1101010100, 0);
        step(2'd1, 8'h00, 2'($urandom), 4'($urandom), "mix_vid2", 1'b1, 10'b0100000000, -8);
        for (int n = 0; n < 16; n++) begin
            step(2'd2, 8'($urandom), 2'($urandom), 4'(n), $sformatf("terc4_%0d", n),
                 1'b1, terc4_tab[n], 0);
        end
        step(2'd3, 8'($urandom), 2'($urandom), 4'($urandom), "guard", 1'b1, 10'b1011001100, 0);
        for (int n = 0; n < 10000; n++) begin
            step(2'd1, 8'($urandom), 2'($urandom), 4'($urandom), "rand_video");
        end
        reset_edge("midstream_reset");
        step(2'd1, 8'h00, 2'($urandom), 4'($urandom), "post_reset_vid", 1'b1, 10'b0100000000, -8);
        step(2'd0, 8'($urandom), 2'b00, 4'($urandom), "drain1");
        step(2'd0, 8'($urandom), 2'b00, 4'($urandom), "drain2");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
